// File: rtl/uflash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uflash_pkg
// Purpose  : Shared widths, wstrb encodings and FSM state encoding for the
//            user-flash read buffer.
// Revision : 1.0 - initial release
// ============================================================================
package uflash_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  localparam logic [3:0] WSTRB_READ  = 4'b0000;
  localparam logic [3:0] WSTRB_PROG  = 4'b1111;
  localparam logic [3:0] WSTRB_ERASE = 4'b0001;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FILL = 2'd1;
  localparam state_t ST_PASS = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage : uflash_pkg
`default_nettype wire

// File: rtl/uflash_rbuf_store.sv
`default_nettype none
// ============================================================================
// Module   : uflash_rbuf_store
// Purpose  : Direct-mapped valid/tag/data arrays with combinational lookup.
// Revision : 1.0 - initial release
// ============================================================================
module uflash_rbuf_store
  import uflash_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_W    = ADDR_W - IDX_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] lookup_idx,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                hit,
  output logic [DATA_W-1:0]   lookup_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                inv_en,
  input  logic [IDX_BITS-1:0] inv_idx,
  input  logic                inv_all
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [DATA_W-1:0]  r_data [ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (inv_all) begin
      r_valid <= '0;
    end else begin
      if (inv_en) r_valid[inv_idx] <= 1'b0;
      if (wr_en)  r_valid[wr_idx]  <= 1'b1;
    end
  end

  // Tag/data carry no reset so they can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[wr_idx]  <= wr_tag;
      r_data[wr_idx] <= wr_data;
    end
  end

  assign hit         = r_valid[lookup_idx] && (r_tag[lookup_idx] == lookup_tag);
  assign lookup_data = r_data[lookup_idx];

endmodule : uflash_rbuf_store
`default_nettype wire

// File: rtl/uflash_rbuf.sv
`default_nettype none
// ============================================================================
// Module   : uflash_rbuf
// Purpose  : Read buffer between the CPU bus and uflash; reads hit a small
//            direct-mapped cache, program/erase pass through and invalidate.
// Revision : 1.0 - initial release
// ============================================================================
module uflash_rbuf
  import uflash_pkg::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready,
  output logic [DATA_W-1:0] data_o,
  output logic              f_sel,
  output logic [3:0]        f_wstrb,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_data_o,
  input  logic              f_ready,
  input  logic [DATA_W-1:0] f_data_i
);

  localparam int TAG_W = ADDR_W - IDX_BITS;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_wstrb;

  logic                w_hit;
  logic [DATA_W-1:0]   w_lookup_data;
  logic                w_fill_done;
  logic                w_pass_done;

  logic                w_ready_d;
  logic [DATA_W-1:0]   w_data_o_d;
  logic                w_f_sel_d;
  logic [3:0]          w_f_wstrb_d;
  logic [ADDR_W-1:0]   w_f_addr_d;
  logic [DATA_W-1:0]   w_f_data_d;
  logic [ADDR_W-1:0]   w_addr_d;
  logic [3:0]          w_wstrb_d;

  assign w_fill_done = (r_state == ST_FILL) && f_ready;
  assign w_pass_done = (r_state == ST_PASS) && f_ready;

  uflash_rbuf_store #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_idx  (addr[IDX_BITS-1:0]),
    .lookup_tag  (addr[ADDR_W-1:IDX_BITS]),
    .hit         (w_hit),
    .lookup_data (w_lookup_data),
    .wr_en       (w_fill_done),
    .wr_idx      (r_addr[IDX_BITS-1:0]),
    .wr_tag      (r_addr[ADDR_W-1:IDX_BITS]),
    .wr_data     (f_data_i),
    .inv_en      (w_pass_done && (r_wstrb == WSTRB_PROG)),
    .inv_idx     (r_addr[IDX_BITS-1:0]),
    .inv_all     (w_pass_done && (r_wstrb == WSTRB_ERASE))
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (sel) begin
          if (wstrb != WSTRB_READ) w_state_next = ST_PASS;
          else if (w_hit)          w_state_next = ST_RESP;
          else                     w_state_next = ST_FILL;
        end
      end
      ST_FILL: if (f_ready) w_state_next = ST_RESP;
      ST_PASS: if (f_ready) w_state_next = ST_RESP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready_d   = 1'b0;
    w_data_o_d  = data_o;
    w_f_sel_d   = f_sel;
    w_f_wstrb_d = f_wstrb;
    w_f_addr_d  = f_addr;
    w_f_data_d  = f_data_o;
    w_addr_d    = r_addr;
    w_wstrb_d   = r_wstrb;
    case (r_state)
      ST_IDLE: begin
        if (sel) begin
          w_addr_d  = addr;
          w_wstrb_d = wstrb;
          if (wstrb == WSTRB_READ) begin
            if (w_hit) begin
              w_data_o_d = w_lookup_data;
              w_ready_d  = 1'b1;
            end else begin
              w_f_sel_d   = 1'b1;
              w_f_wstrb_d = WSTRB_READ;
              w_f_addr_d  = addr;
            end
          end else begin
            w_f_sel_d   = 1'b1;
            w_f_wstrb_d = wstrb;
            w_f_addr_d  = addr;
            w_f_data_d  = data_i;
          end
        end
      end
      // f_sel must already be low when uflash re-enters idle after f_ready.
      ST_FILL: begin
        if (f_ready) begin
          w_data_o_d  = f_data_i;
          w_f_sel_d   = 1'b0;
          w_f_wstrb_d = WSTRB_READ;
          w_ready_d   = 1'b1;
        end
      end
      ST_PASS: begin
        if (f_ready) begin
          w_data_o_d = '0;
          w_f_sel_d  = 1'b0;
          w_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready    <= 1'b0;
      data_o   <= '0;
      f_sel    <= 1'b0;
      f_wstrb  <= '0;
      f_addr   <= '0;
      f_data_o <= '0;
      r_addr   <= '0;
      r_wstrb  <= '0;
    end else begin
      ready    <= w_ready_d;
      data_o   <= w_data_o_d;
      f_sel    <= w_f_sel_d;
      f_wstrb  <= w_f_wstrb_d;
      f_addr   <= w_f_addr_d;
      f_data_o <= w_f_data_d;
      r_addr   <= w_addr_d;
      r_wstrb  <= w_wstrb_d;
    end
  end

endmodule : uflash_rbuf
`default_nettype wire
